// File: rtl/signed_bcd_pkg.sv
// Shared definitions for the signed binary-to-BCD converter.
//   state_t        : controller FSM states
//   WIDTH / NDIG   : operand width and number of BCD output digits
//   SHIFT_STEPS    : double-dabble iterations (one per operand bit)
//   BCD_ADJ_*      : digit correction threshold and addend
package signed_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WIDTH          = 8;
    localparam int NDIG           = 3;
    localparam int SHIFT_STEPS    = 8;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: one BCD digit in, corrected digit out.
//   d : current 4-bit BCD digit
//   q : d + 3 when d >= 5, otherwise d unchanged
// Purely combinational.
module bcd_digit_adj
    import signed_bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= 4'(BCD_ADJ_THRESH)) begin
            q = d + 4'(BCD_ADJ_ADD);
        end
    end

endmodule

// File: rtl/signed_bcd_ctrl.sv
// Signed 8-bit to sign + 3-digit BCD converter with valid/ready handshakes.
// A request is captured in IDLE, its magnitude taken in ABS, converted by
// eight double-dabble steps in SHIFT, and presented in DONE until consumed.
// Fixed latency: out_valid rises 9 clock edges after the accepting edge.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : din carries a request
//   in_ready  : high only in IDLE
//   din       : two's-complement operand
//   out_valid : high only in DONE
//   out_ready : consumer takes the result (ignored outside DONE)
//   neg       : sign of the last converted operand
//   bcd_h/t/o : hundreds / tens / ones digits of |din|, held until next result
// Only WIDTH=8 and NDIG=3 are supported.
module signed_bcd_ctrl
    import signed_bcd_pkg::*;
#(
    parameter int WIDTH = signed_bcd_pkg::WIDTH,
    parameter int NDIG  = signed_bcd_pkg::NDIG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             neg,
    output logic [3:0]       bcd_h,
    output logic [3:0]       bcd_t,
    output logic [3:0]       bcd_o
);

    localparam int BCDW = 4 * NDIG;

    state_t            state_reg;
    logic [2:0]        count_reg;
    logic [WIDTH-1:0]  op_reg;
    logic [WIDTH-1:0]  mag_reg;
    logic [BCDW-1:0]   bcd_reg;
    logic              neg_r_reg;

    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              neg_reg;
    logic [3:0]        bcd_h_reg;
    logic [3:0]        bcd_t_reg;
    logic [3:0]        bcd_o_reg;

    logic [BCDW-1:0]       bcd_adj;
    logic [BCDW+WIDTH-1:0] shift_next;

    // Per-digit correction ahead of each shift.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (bcd_reg[4*gi +: 4]),
                .q (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // One double-dabble step: corrected digits and magnitude shift left as one
    // word; the top digit bit can never be set for an 8-bit magnitude.
    assign shift_next = {bcd_adj[BCDW-2:0], mag_reg, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            op_reg        <= '0;
            mag_reg       <= '0;
            bcd_reg       <= '0;
            neg_r_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            neg_reg       <= 1'b0;
            bcd_h_reg     <= '0;
            bcd_t_reg     <= '0;
            bcd_o_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        op_reg       <= din;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ABS;
                    end
                end
                ABS: begin
                    // -128 negates to itself; read as unsigned it is 128.
                    neg_r_reg <= op_reg[WIDTH-1];
                    mag_reg   <= op_reg[WIDTH-1] ? (~op_reg) + 8'd1 : op_reg;
                    bcd_reg   <= '0;
                    count_reg <= '0;
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    {bcd_reg, mag_reg} <= shift_next;
                    count_reg          <= count_reg + 3'd1;
                    if (count_reg == 3'(SHIFT_STEPS - 1)) begin
                        // Result loads on the same edge as the last step.
                        neg_reg       <= neg_r_reg;
                        bcd_h_reg     <= shift_next[WIDTH+8 +: 4];
                        bcd_t_reg     <= shift_next[WIDTH+4 +: 4];
                        bcd_o_reg     <= shift_next[WIDTH   +: 4];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign neg       = neg_reg;
    assign bcd_h     = bcd_h_reg;
    assign bcd_t     = bcd_t_reg;
    assign bcd_o     = bcd_o_reg;

endmodule

// File: tb/tb_signed_bcd_ctrl.sv
// Bench for signed_bcd_ctrl: table-driven conversions through a scoreboard
// queue, plus hand sequences for output hold, mid-conversion reset and
// back-to-back requests. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_signed_bcd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] din = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       neg;
    logic [3:0] bcd_h, bcd_t, bcd_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [12:0] sb_q[$];

    typedef struct {
        logic [7:0]  d;
        logic [12:0] exp;   // {neg, hundreds, tens, ones}
        int          hold;  // cycles with out_ready=0 after out_valid
    } vec_t;

    vec_t tbl[7];

    signed_bcd_ctrl #(.WIDTH(8), .NDIG(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .neg       (neg),
        .bcd_h     (bcd_h),
        .bcd_t     (bcd_t),
        .bcd_o     (bcd_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] model(input logic [7:0] d);
        int v;
        int a;
        v = int'($signed(d));
        a = (v < 0) ? -v : v;
        return {(v < 0), 4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int result();
        return int'({neg, bcd_h, bcd_t, bcd_o});
    endfunction

    // One full conversion; call at a falling edge.
    task automatic run_conv(input logic [7:0] d, input logic [12:0] exp, input int hold);
        int w;
        int lat;
        logic [12:0] e;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_req", int'(in_ready), 1);
        in_valid = 1'b1;
        din      = d;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        din      = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 9);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            e = 13'h0;
        end else begin
            e = sb_q.pop_front();
        end
        chk($sformatf("result_din_%02h", d), result(), int'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", result(), int'(e));
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_retain", result(), int'(e));
        $display("conv din=%02h result=%04h latency=%0d hold=%0d", d, result(), lat, hold);
    endtask

    initial begin
        int ones;
        int conv;
        int cyc;
        logic [12:0] e;
        logic [7:0]  r;

        tbl[0] = '{8'h00, 13'h0000, 0};
        tbl[1] = '{8'h7F, 13'h0127, 0};
        tbl[2] = '{8'h01, 13'h0001, 0};
        tbl[3] = '{8'hFF, 13'h1001, 0};
        tbl[4] = '{8'h80, 13'h1128, 0};
        tbl[5] = '{8'h9C, 13'h1100, 0};
        tbl[6] = '{8'hD6, 13'h1042, 5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", result(), 0);

        // First request presented on the very edge after release
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_conv(tbl[i].d, tbl[i].exp, tbl[i].hold);
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            run_conv(r, model(r), i % 3);
        end

        // Reset in the 4th SHIFT cycle aborts the conversion
        in_valid = 1'b1;
        din      = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_result", result(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ones++;
        end
        chk("abort_no_out_valid", ones, 0);
        chk("abort_result_after", result(), 0);
        $display("abort din=55 out_valid_count=%0d", ones);
        run_conv(8'h0A, 13'h0010, 0);

        // Back-to-back: in_valid held high, din changing every cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        conv = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("b2b_scoreboard_nonempty", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("b2b_result", result(), int'(e));
                    $display("b2b result=%04h expected=%04h", result(), e);
                    conv++;
                end
            end
            din = 8'($urandom);
            if (in_ready) sb_q.push_back(model(din));
            @(negedge clk);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                chk("b2b_result", result(), int'(e));
                $display("b2b result=%04h expected=%04h", result(), e);
                conv++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("b2b_drained", sb_q.size(), 0);
        chk("b2b_conversions", int'(conv >= 5), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
